// File: rtl/sipo_deser_if.sv
// sipo_deser_if -- bundles the serial receive side and the word output side
// of the deserializer. The slave modport is the deserializer itself; the
// master modport is whatever drives the link and consumes the words.
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             sin_first;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             resync;
  logic             parity_err;

  modport master (
    output sin, sin_valid, sin_first, out_ready,
    input  data_out, out_valid, overrun, resync, parity_err
  );

  modport slave (
    input  sin, sin_valid, sin_first, out_ready,
    output data_out, out_valid, overrun, resync, parity_err
  );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser -- serial-in, parallel-out deserializer. Assembles MSB-first
// framed bits into WIDTH-bit words and presents them through a one-entry
// valid/ready holding register.
// Optional feature: define SIPO_PARITY_EN to expect one even-parity bit after
// the data bits of every frame; otherwise parity_err is constant 0.
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sipo_deser_if.slave bus
);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  // The whole word must be held while waiting for the parity bit.
  localparam int SR_W = WIDTH;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
  // The final bit goes straight into data_out, so only WIDTH-1 bits are kept.
  localparam int SR_W = WIDTH - 1;
`endif

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  shreg;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;
  logic             resync_q;
  logic             parity_err_q;

  logic             start;
  logic             data_bit;
  logic             last_data;
  logic             commit;
  logic             can_load;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] commit_word;

  // Decode the current bit and decide whether a finished word is ready to commit.
  always_comb begin
    // NOTE: every signal gets a value before any condition so no latch is inferred.
    start       = bus.sin_valid & bus.sin_first;
    data_bit    = bus.sin_valid & ~bus.sin_first;
    next_word   = {shreg[WIDTH-2:0], bus.sin};
    last_data   = (state == SHIFT) && data_bit && (cnt == LAST);
    can_load    = !valid_q || bus.out_ready;
`ifdef SIPO_PARITY_EN
    commit      = (state == PAR) && data_bit && !(^{shreg, bus.sin});
    commit_word = shreg;
`else
    commit      = last_data;
    commit_word = next_word;
`endif
  end

  // Frame FSM, shift register, holding register and event pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      resync_q     <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      overrun_q    <= 1'b0;
      resync_q     <= 1'b0;
      parity_err_q <= 1'b0;

      // Holding register: a commit may reuse the slot being drained this cycle.
      if (commit && can_load) begin
        data_q  <= commit_word;
        valid_q <= 1'b1;
      end else begin
        if (valid_q && bus.out_ready) valid_q <= 1'b0;
        if (commit) overrun_q <= 1'b1;
      end

      if (start) begin
        // A frame start always wins, even on what would be the last bit.
        resync_q <= (state != IDLE);
        shreg    <= SR_W'(bus.sin);   // ends up as the MSB after WIDTH-1 shifts
        cnt      <= CNT_W'(1);
        state    <= SHIFT;
      end else if (data_bit) begin
        case (state)
          SHIFT: begin
            shreg <= SR_W'(next_word);
            cnt   <= cnt + 1'b1;
            if (last_data) begin
              cnt <= '0;
`ifdef SIPO_PARITY_EN
              state <= PAR;
`else
              state <= IDLE;
`endif
            end
          end
`ifdef SIPO_PARITY_EN
          PAR: begin
            parity_err_q <= ^{shreg, bus.sin};
            state        <= IDLE;
          end
`endif
          default: ;  // IDLE: bits outside a frame are discarded
        endcase
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.resync     = resync_q;
  assign bus.parity_err = parity_err_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser -- directed and randomized checks of sipo_deser against a
// frame-level reference model built from bit lists.
module tb_sipo_deser;
  localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(WIDTH)) bus ();
  sipo_deser #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int ovr_seen = 0;
  int rsy_seen = 0;
  int perr_seen = 0;

  // Reference model state: bits of the current frame, and the held word.
  int               m_bits[$];
  bit               m_in_frame;
  bit               m_hv;
  logic [WIDTH-1:0] m_word;
  bit               e_ovr, e_rsy, e_par;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit s, input bit v, input bit f, input bit r);
    bit               do_commit = 0;
    logic [WIDTH-1:0] w = '0;
    int               ones = 0;
    if (!rst_n) begin
      m_bits.delete(); m_in_frame = 0; m_hv = 0; m_word = '0;
      e_ovr = 0; e_rsy = 0; e_par = 0;
      return;
    end
    e_ovr = 0; e_rsy = 0; e_par = 0;
    if (v && f) begin
      if (m_in_frame) e_rsy = 1;
      m_bits.delete();
      m_bits.push_back(int'(s));
      m_in_frame = 1;
    end else if (v && m_in_frame) begin
      m_bits.push_back(int'(s));
      if (m_bits.size() == FLEN) begin
        for (int i = 0; i < WIDTH; i++) w = WIDTH'(w * 2 + m_bits[i]);
        foreach (m_bits[i]) ones += m_bits[i];
        if (ones % 2 == 0 || FLEN == WIDTH) do_commit = 1;
        else e_par = 1;
        m_bits.delete();
        m_in_frame = 0;
      end
    end
    if (do_commit) begin
      if (!m_hv || r) begin m_hv = 1; m_word = w; end
      else e_ovr = 1;
    end else if (m_hv && r) begin
      m_hv = 0;
    end
  endtask

  // One clock: drive inputs, clock the DUT and model, compare away from the edge.
  task automatic step(input bit s, input bit v, input bit f, input bit r);
    bus.sin = s; bus.sin_valid = v; bus.sin_first = f; bus.out_ready = r;
    @(posedge clk);
    model_step(s, v, f, r);
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_hv));
    if (m_hv) check("data_out", 32'(bus.data_out), 32'(m_word));
    check("overrun", 32'(bus.overrun), 32'(e_ovr));
    check("resync", 32'(bus.resync), 32'(e_rsy));
    check("parity_err", 32'(bus.parity_err), 32'(e_par));
    if (bus.overrun) ovr_seen++;
    if (bus.resync) rsy_seen++;
    if (bus.parity_err) perr_seen++;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] word, input int gap,
                            input bit r, input bit bad_par);
    bit b[$];
    for (int i = WIDTH - 1; i >= 0; i--) b.push_back(word[i]);
    if (FLEN > WIDTH) b.push_back((^word) ^ bad_par);
    foreach (b[i]) begin
      step(b[i], 1'b1, i == 0, r);
      if (i < b.size() - 1)
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, r);
    end
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit r);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, i == n - 1, r);
  endtask

  task automatic clear_seen();
    ovr_seen = 0; rsy_seen = 0; perr_seen = 0;
  endtask

  initial begin
    bus.sin = 0; bus.sin_valid = 0; bus.sin_first = 0; bus.out_ready = 0;
    rst_n = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_data_out", 32'(bus.data_out), 32'h0);
    check("reset_out_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1;

    // Plain frame, consumer ready.
    clear_seen();
    send_frame(4'hB, 0, 1'b1, 1'b0);
    check("tp1_valid", 32'(bus.out_valid), 32'h1);
    check("tp1_data", 32'(bus.data_out), 32'hB);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("tp1_drained", 32'(bus.out_valid), 32'h0);

    // Gapped frame, no pulses.
    send_frame(4'hC, 3, 1'b1, 1'b0);
    check("tp2_data", 32'(bus.data_out), 32'hC);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("tp2_pulses", 32'(ovr_seen + rsy_seen + perr_seen), 32'h0);

    // Back-to-back frames with consumer stalled.
    clear_seen();
    send_frame(4'hA, 0, 1'b0, 1'b0);
    send_frame(4'h5, 0, 1'b0, 1'b0);
    check("tp3_data", 32'(bus.data_out), 32'hA);
    check("tp3_overrun", 32'(bus.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("tp3_ovr_once", 32'(ovr_seen), 32'h1);
    check("tp3_held", 32'(bus.data_out), 32'hA);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("tp3_cleared", 32'(bus.out_valid), 32'h0);

    // Abandoned partial frame.
    clear_seen();
    send_bits(32'b10, 2, 1'b1);
    send_frame(4'h6, 0, 1'b1, 1'b0);
    check("tp4_resync", 32'(rsy_seen), 32'h1);
    check("tp4_data", 32'(bus.data_out), 32'h6);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    clear_seen();
    send_frame(4'hB, 0, 1'b1, 1'b0);
    check("tp5_data", 32'(bus.data_out), 32'hB);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(4'hB, 0, 1'b1, 1'b1);
    check("tp5_perr", 32'(perr_seen), 32'h1);
    check("tp5_novalid", 32'(bus.out_valid), 32'h0);
`endif

    // Reset mid-frame with a word held.
    send_frame(4'h9, 0, 1'b0, 1'b0);
    send_bits(32'b11, 2, 1'b0);
    rst_n = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("tp6_data_out", 32'(bus.data_out), 32'h0);
    check("tp6_out_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1;
    send_frame(4'h7, 0, 1'b1, 1'b0);
    check("tp6_data", 32'(bus.data_out), 32'h7);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      bit v, f, s, r;
      v = 1'($urandom_range(0, 1));
      f = v && ($urandom_range(0, FLEN) == 0);
      s = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 999) != 0);
      step(s, v, f, r);
    end
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
